// File: rtl/kronos_clint.sv
// kronos_clint: machine-level core-local interruptor.
// Holds mtime, mtimecmp and msip behind a req/ack data-bus slave.
module kronos_clint #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic        software_interrupt,
  output logic        timer_interrupt
);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

  state_t      state;
  logic [15:0] div_cnt;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;

  logic [2:0]  idx;
  logic        access;
  logic        wr;
  logic        tick;
  logic        wr_msip;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_mt_lo;
  logic        wr_mt_hi;
  logic [31:0] mt_lo_next;
  logic [31:0] mt_hi_next;
  logic [31:0] rd_mux;
  logic        unused_addr;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  m
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = m[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
    end
    return r;
  endfunction

  assign idx         = data_addr[4:2];
  assign unused_addr = ^{data_addr[31:5], data_addr[1:0]};

  assign access    = (state == IDLE) && data_req && !data_ack;
  assign wr        = access && data_wr_en;
  assign tick      = (div_cnt == DIV_MAX);

  assign wr_msip   = wr && (idx == 3'd0) && data_mask[0];
  assign wr_cmp_lo = wr && (idx == 3'd2);
  assign wr_cmp_hi = wr && (idx == 3'd3);
  assign wr_mt_lo  = wr && (idx == 3'd4);
  assign wr_mt_hi  = wr && (idx == 3'd5);

  assign software_interrupt = msip;

  // Next mtime halves for a bus write; the unwritten half is untouched
  always_comb begin
    mt_lo_next = mtime[31:0];
    mt_hi_next = mtime[63:32];
    if (wr_mt_lo) begin
      mt_lo_next = merge(mtime[31:0], data_wr_data, data_mask);
    end
    if (wr_mt_hi) begin
      mt_hi_next = merge(mtime[63:32], data_wr_data, data_mask);
    end
  end

  // Read-data mux over the word index; reserved words read zero
  always_comb begin
    rd_mux = '0;
    case (idx)
      3'd0:    rd_mux = {31'd0, msip};
      3'd2:    rd_mux = mtimecmp[31:0];
      3'd3:    rd_mux = mtimecmp[63:32];
      3'd4:    rd_mux = mtime[31:0];
      3'd5:    rd_mux = mtime[63:32];
      default: rd_mux = '0;
    endcase
  end

  // Prescaler and mtime; a bus write beats a same-cycle tick
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      div_cnt <= '0;
      mtime   <= '0;
    end else if (wr_mt_lo || wr_mt_hi) begin
      div_cnt <= '0;
      mtime   <= {mt_hi_next, mt_lo_next};
    end else if (tick) begin
      div_cnt <= '0;
      mtime   <= mtime + 64'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Compare register and software-interrupt bit
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else begin
      if (wr_cmp_lo) begin
        mtimecmp[31:0] <= merge(mtimecmp[31:0], data_wr_data, data_mask);
      end
      if (wr_cmp_hi) begin
        mtimecmp[63:32] <= merge(mtimecmp[63:32], data_wr_data, data_mask);
      end
      if (wr_msip) begin
        msip <= data_wr_data[0];
      end
    end
  end

  // Timer match registered every cycle, one cycle behind the operands
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      timer_interrupt <= 1'b0;
    end else begin
      timer_interrupt <= (mtime >= mtimecmp);
    end
  end

  // Bus FSM: accept in IDLE, pulse ack for one cycle, ignore req meanwhile
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state        <= IDLE;
      data_ack     <= 1'b0;
      data_rd_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            state    <= ACK;
            data_ack <= 1'b1;
            if (!data_wr_en) begin
              data_rd_data <= rd_mux;
            end
          end
        end
        ACK: begin
          state    <= IDLE;
          data_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/kronos_clint.md
# kronos_clint

Machine-level core-local interruptor: the source side of the software and timer interrupt lines that the CSR unit consumes as `software_interrupt` and `timer_interrupt`. It holds a 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and an `msip` bit. Software reaches them through a memory-mapped data-bus slave port using the core's req/ack handshake. It sits on the system data bus beside RAM and peripherals. Its interrupt outputs wire directly to the core.

## Interface
Parameters:
- `CLK_DIV`, default 1: number of `clk` cycles per `mtime` tick; legal range 1..65535.

Ports:
- `clk`  in  1  core clock
- `rstz`  in  1  reset, asynchronous, active-low
- `data_addr`  in  32  byte address; only bits [4:2] decoded; the interconnect handles select
- `data_wr_data`  in  32  write data
- `data_mask`  in  4  byte-enable for writes
- `data_wr_en`  in  1  1 = write, 0 = read
- `data_req`  in  1  request, held high until `data_ack`
- `data_rd_data`  out  32  registered read data, valid while `data_ack` = 1
- `data_ack`  out  1  single-cycle completion pulse
- `software_interrupt`  out  1  equals `msip`
- `timer_interrupt`  out  1  registered (`mtime >= mtimecmp`)

## Operation
- Register map (byte offset, word index = `data_addr[4:2]`):
  - 0x00: MSIP; only bit 0 is writable; other bits read as 0.
  - 0x04: reserved; reads return 0, writes are ignored.
  - 0x08 / 0x0C: MTIMECMP low / high.
  - 0x10 / 0x14: MTIME low / high.
  - 0x18, 0x1C: reserved, same behaviour as 0x04.
- Writes are byte-masked. Only bytes with `data_mask[i]` = 1 are updated, for every register. MSIP bit 0 updates only when `data_mask[0]` = 1.
- Bus FSM, two states:
  - IDLE: when `data_req` = 1 and `data_ack` = 0, perform the access and go to ACK.
    - A read samples the register into `data_rd_data`.
    - A write updates the register.
  - ACK: `data_ack` = 1 for exactly one cycle, then return to IDLE.
  - `data_req` is ignored while in ACK, so back-to-back requests cost 2 cycles each.
- Prescaler: counter `div_cnt` counts 0..CLK_DIV-1. A tick fires when `div_cnt` = CLK_DIV-1; the counter then wraps to 0. With CLK_DIV = 1, every cycle is a tick.
- `mtime` increments by 1 on each tick as a full 64-bit add, with carry from the low half into the high half. At 0xFFFF_FFFF_FFFF_FFFF it wraps to 0.
- A bus write to MTIME low or high in the same cycle as a tick:
  - The write wins and the tick's increment is discarded.
  - The unwritten half keeps its pre-write value, with no carry.
  - `div_cnt` resets to 0 on any MTIME write.
- Comparison `mtime >= mtimecmp` is unsigned 64-bit. The result is registered into `timer_interrupt` every cycle.
- Software clears the timer interrupt by writing MTIMECMP above MTIME. To avoid a spurious match, the recommended order is: high ← 0xFFFF_FFFF, then low, then high.
- Reads of MTIME low and high are independent snapshots. Software is responsible for the hi/lo/hi re-read.

## Timing
- Reset values:
  - `mtime` = 0, `div_cnt` = 0, `msip` = 0.
  - `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, so no interrupt after reset.
  - `data_ack` = 0, `data_rd_data` = 0, FSM = IDLE.
  - `software_interrupt` = 0, `timer_interrupt` = 0.
- Access latency: `data_req` sampled high in cycle N gives `data_ack` high in cycle N+1. The write takes effect at the edge ending cycle N.
- `software_interrupt` rises in cycle N+1 after a write of MSIP = 1.
- `timer_interrupt` lags the `mtime`/`mtimecmp` change that causes a match (or mismatch) by one cycle.
- Read data reflects register state at the cycle-N edge and excludes any update made in that same edge.
- Asserting `rstz` low mid-transaction:
  - All state returns to reset values immediately.
  - A pending `data_ack` is dropped; the master must reissue the request.

## Test plan
- Reset check: assert `rstz` low, then release. Read 0x0C → 0xFFFF_FFFF, 0x10 → small count, 0x00 → 0. Both interrupts stay 0.
- MSIP handshake: write 0x00 = 0x1 with mask 0xF. `data_ack` pulses once in the cycle after req, and `software_interrupt` = 1. Repeat with mask 0x0: no change. Write 0x0 → `software_interrupt` = 0.
- Timer match with CLK_DIV = 4: write MTIME = 0 and MTIMECMP = 10. `timer_interrupt` rises exactly 41 cycles after the MTIME write completes (10 ticks × 4, plus 1 register stage). Then write MTIMECMP high = 0xFFFF_FFFF → the interrupt falls 1 cycle later.
- Carry: write MTIME low = 0xFFFF_FFFE and high = 0x0000_0001. After 2 ticks, MTIME reads low 0x0, high 0x2.
- Write/tick collision with CLK_DIV = 1: write MTIME low = 0x100. The next read of low returns 0x100 plus the ticks elapsed after the write, with no extra increment. Byte-masked write to MTIMECMP with mask 0x2 and data 0xAB00 → only byte 1 changes.
- Reserved and wrap: read 0x04 and 0x1C → 0; writes to them have no effect. Set MTIME = 0xFFFF_FFFF_FFFF_FFFF → after 1 tick, reads 0.
